lc4_regfile_nzp: RTL and testbench

Architectural state block feeding the LC4 ALU: an 8×16 register file with two combinational read ports that drive the ALU's `i_r1data`/`i_r2data`, plus the NZP condition register, PC register and PSR privilege bit. It sits between decode and execute. ALU results return through the single write port. Branch resolution against the stored NZP is produced here and consumed by next-PC logic.

---
 rtl/lc4_regfile_nzp.sv | 113 +++++++++++
 tb/tb_lc4_regfile_nzp.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lc4_regfile_nzp.sv
// lc4_regfile_nzp: LC4 architectural state for the execute stage.
// Holds the 8x16 register file (two combinational read ports, one write port),
// the NZP condition register, the PC and the PSR privilege bit. It also resolves
// branches against the NZP value.
// Optional macro LC4_RF_BYPASS_EN: the read ports and the NZP/branch outputs
// forward the value being written in the current cycle.
module lc4_regfile_nzp #(
    parameter int unsigned W        = 16,
    parameter logic [15:0] RESET_PC = 16'h8200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gwe,
    input  logic [2:0]   i_rs,
    output logic [W-1:0] o_rs_data,
    input  logic [2:0]   i_rt,
    output logic [W-1:0] o_rt_data,
    input  logic [2:0]   i_rd,
    input  logic [W-1:0] i_wdata,
    input  logic         i_rd_we,
    input  logic         i_nzp_we,
    input  logic [2:0]   i_br_mask,
    output logic         o_br_taken,
    input  logic [W-1:0] i_next_pc,
    input  logic         i_pc_we,
    output logic [W-1:0] o_pc,
    input  logic         i_trap,
    input  logic         i_rti,
    output logic         o_priv,
    output logic [2:0]   o_nzp
);

    localparam int unsigned NUM_REGS = 8;

    logic [W-1:0] regs [NUM_REGS];
    logic [2:0]   nzp_q;
    logic [W-1:0] pc_q;
    logic         priv_q;
    logic [2:0]   nzp_new;
    logic [2:0]   nzp_eff;
    logic         rd_wr;
    logic         nzp_wr;

    assign rd_wr  = gwe & i_rd_we;
    assign nzp_wr = gwe & i_nzp_we;

    // Two's complement sign/zero classification of the incoming write data
    always_comb begin
        nzp_new = 3'b001;
        if (i_wdata[W-1])
            nzp_new = 3'b100;
        else if (i_wdata == W'(0))
            nzp_new = 3'b010;
    end

    // Register file: async reset clears all eight entries, R0 included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++)
                regs[i] <= '0;
        end else if (rd_wr) begin
            regs[i_rd] <= i_wdata;
        end
    end

    // NZP, PC and privilege state; TRAP has priority over RTI
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzp_q  <= 3'b000;
            pc_q   <= W'(RESET_PC);
            priv_q <= 1'b1;
        end else if (gwe) begin
            if (i_nzp_we)
                nzp_q <= nzp_new;
            if (i_pc_we)
                pc_q <= i_next_pc;
            if (i_trap)
                priv_q <= 1'b1;
            else if (i_rti)
                priv_q <= 1'b0;
        end
    end

`ifdef LC4_RF_BYPASS_EN
    // Read ports and NZP forward the in-flight write; reset masks forwarding
    always_comb begin
        o_rs_data = regs[i_rs];
        o_rt_data = regs[i_rt];
        nzp_eff   = nzp_q;
        if (!rst) begin
            if (rd_wr && (i_rd == i_rs))
                o_rs_data = i_wdata;
            if (rd_wr && (i_rd == i_rt))
                o_rt_data = i_wdata;
            if (nzp_wr)
                nzp_eff = nzp_new;
        end
    end
`else
    // Read ports and NZP reflect stored state only
    always_comb begin
        o_rs_data = regs[i_rs];
        o_rt_data = regs[i_rt];
        nzp_eff   = nzp_q;
    end
`endif

    assign o_nzp      = nzp_eff;
    assign o_br_taken = |(i_br_mask & nzp_eff);
    assign o_pc       = pc_q;
    assign o_priv     = priv_q;

endmodule

// File: tb/tb_lc4_regfile_nzp.sv
// tb_lc4_regfile_nzp: directed self-checking bench for lc4_regfile_nzp.
module tb_lc4_regfile_nzp;

    logic        clk = 1'b0;
    logic        rst;
    logic        gwe;
    logic [2:0]  i_rs, i_rt, i_rd;
    logic [15:0] o_rs_data, o_rt_data;
    logic [15:0] i_wdata;
    logic        i_rd_we, i_nzp_we;
    logic [2:0]  i_br_mask;
    logic        o_br_taken;
    logic [15:0] i_next_pc;
    logic        i_pc_we;
    logic [15:0] o_pc;
    logic        i_trap, i_rti;
    logic        o_priv;
    logic [2:0]  o_nzp;

    int checks   = 0;
    int failures = 0;

    lc4_regfile_nzp dut (
        .clk(clk), .rst(rst), .gwe(gwe),
        .i_rs(i_rs), .o_rs_data(o_rs_data),
        .i_rt(i_rt), .o_rt_data(o_rt_data),
        .i_rd(i_rd), .i_wdata(i_wdata), .i_rd_we(i_rd_we),
        .i_nzp_we(i_nzp_we), .i_br_mask(i_br_mask), .o_br_taken(o_br_taken),
        .i_next_pc(i_next_pc), .i_pc_we(i_pc_we), .o_pc(o_pc),
        .i_trap(i_trap), .i_rti(i_rti), .o_priv(o_priv), .o_nzp(o_nzp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; gwe = 1'b0;
        i_rs = 3'd0; i_rt = 3'd0; i_rd = 3'd0; i_wdata = 16'h0;
        i_rd_we = 1'b0; i_nzp_we = 1'b0; i_br_mask = 3'b000;
        i_next_pc = 16'h0; i_pc_we = 1'b0; i_trap = 1'b0; i_rti = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("reset_pc", o_pc, 16'h8200);
        chk("reset_priv", 16'(o_priv), 16'h1);
        chk("reset_nzp", 16'(o_nzp), 16'h0);
        i_br_mask = 3'b111; #1;
        chk("reset_br_taken", 16'(o_br_taken), 16'h0);

        // Pending writes everywhere, then reset mid-cycle
        gwe = 1'b1; i_rd = 3'd3; i_rs = 3'd3; i_rt = 3'd3; i_wdata = 16'h1234;
        i_rd_we = 1'b1; i_nzp_we = 1'b1; i_pc_we = 1'b1; i_next_pc = 16'h1111;
        i_rti = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_pc", o_pc, 16'h8200);
        chk("midrst_priv", 16'(o_priv), 16'h1);
        chk("midrst_nzp", 16'(o_nzp), 16'h0);
        chk("midrst_rs", o_rs_data, 16'h0);
        chk("midrst_rt", o_rt_data, 16'h0);
        step();
        chk("rst_held_pc", o_pc, 16'h8200);
        chk("rst_held_rs", o_rs_data, 16'h0);
        rst = 1'b0;
        i_nzp_we = 1'b0; i_pc_we = 1'b0; i_rti = 1'b0;
        step();
        chk("r3_write", o_rs_data, 16'h1234);
        chk("pc_not_written", o_pc, 16'h8200);
        i_rd_we = 1'b0;

        // gwe low blocks the write
        i_rd = 3'd5; i_rs = 3'd5; i_wdata = 16'hBEEF; i_rd_we = 1'b1; gwe = 1'b0;
        i_nzp_we = 1'b1; i_pc_we = 1'b1; i_next_pc = 16'h7777; i_rti = 1'b1;
        step();
        chk("r5_gwe0", o_rs_data, 16'h0);
        chk("nzp_gwe0", 16'(o_nzp), 16'h0);
        chk("pc_gwe0", o_pc, 16'h8200);
        chk("priv_gwe0", 16'(o_priv), 16'h1);
        i_nzp_we = 1'b0; i_pc_we = 1'b0; i_rti = 1'b0;
        gwe = 1'b1;
        step();
        chk("r5_gwe1", o_rs_data, 16'hBEEF);
        i_rd_we = 1'b0;

        // NZP classification without register writes
        i_nzp_we = 1'b1; i_rd = 3'd3; i_rt = 3'd3;
        i_wdata = 16'h8000; step();
        chk("nzp_neg", 16'(o_nzp), 16'h4);
        i_wdata = 16'h0000; step();
        chk("nzp_zero", 16'(o_nzp), 16'h2);
        i_wdata = 16'h0001; step();
        chk("nzp_pos", 16'(o_nzp), 16'h1);
        i_nzp_we = 1'b0; #1;
        i_br_mask = 3'b110; #1;
        chk("br_mask110", 16'(o_br_taken), 16'h0);
        i_br_mask = 3'b011; #1;
        chk("br_mask011", 16'(o_br_taken), 16'h1);
        i_br_mask = 3'b000; #1;
        chk("br_mask000", 16'(o_br_taken), 16'h0);
        i_br_mask = 3'b111; #1;
        chk("br_mask111", 16'(o_br_taken), 16'h1);
        chk("nzp_no_r3_change", o_rt_data, 16'h1234);
        chk("nzp_no_r5_change", o_rs_data, 16'hBEEF);

        // R0 is an ordinary writable register
        i_rd = 3'd0; i_rs = 3'd0; i_wdata = 16'hFFFF; i_rd_we = 1'b1; step();
        i_rd_we = 1'b0; #1;
        chk("r0_write", o_rs_data, 16'hFFFF);

        // Same-cycle read/write of R2
        i_rd = 3'd2; i_wdata = 16'h0055; i_rd_we = 1'b1; step();
        i_rd_we = 1'b0; i_rs = 3'd2; i_rt = 3'd2; #1;
        chk("r2_old", o_rs_data, 16'h0055);
        i_wdata = 16'h00AA; i_rd_we = 1'b1; #1;
`ifdef LC4_RF_BYPASS_EN
        chk("r2_pre_rs", o_rs_data, 16'h00AA);
        chk("r2_pre_rt", o_rt_data, 16'h00AA);
`else
        chk("r2_pre_rs", o_rs_data, 16'h0055);
        chk("r2_pre_rt", o_rt_data, 16'h0055);
`endif
        step();
        i_rd_we = 1'b0; #1;
        chk("r2_post_rs", o_rs_data, 16'h00AA);
        chk("r2_post_rt", o_rt_data, 16'h00AA);

        // Privilege bit and PC
        i_rti = 1'b1; step();
        chk("priv_rti", 16'(o_priv), 16'h0);
        i_trap = 1'b1; step();
        chk("priv_trap_rti", 16'(o_priv), 16'h1);
        i_trap = 1'b0; step();
        chk("priv_rti2", 16'(o_priv), 16'h0);
        i_rti = 1'b0; step();
        chk("priv_hold", 16'(o_priv), 16'h0);
        gwe = 1'b0; i_trap = 1'b1; step();
        chk("priv_gwe0_trap", 16'(o_priv), 16'h0);
        gwe = 1'b1; i_trap = 1'b0;
        i_pc_we = 1'b1; i_next_pc = 16'h0042; step();
        chk("pc_write", o_pc, 16'h0042);
        gwe = 1'b0; i_next_pc = 16'h9999; step();
        chk("pc_gwe0_hold", o_pc, 16'h0042);
        i_pc_we = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
